// File: rtl/reg_file.sv
// Architectural register file: 16 x 16-bit, two bypassed combinational read
// ports, one write port, and a per-register pending-write scoreboard.
module reg_file #(
    parameter logic [15:0] SP_INIT = 16'hFFFF,
    parameter logic [15:0] DS_INIT = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [3:0]  i_p0_addr,
    input  logic [3:0]  i_p1_addr,
    input  logic        i_re0,
    input  logic        i_re1,
    output logic [15:0] o_p0,
    output logic [15:0] o_p1,
    input  logic        i_we,
    input  logic [3:0]  i_dst_addr,
    input  logic [15:0] i_dst,
    input  logic        i_issue_valid,
    input  logic [3:0]  i_issue_addr,
    output logic        o_stall
);

    logic [15:0] r_regs [16];
    logic [1:0]  r_cnt  [16];
    logic [1:0]  w_cnt_nxt [16];

    logic [3:0]  w_addr [2];
    logic        w_re   [2];
    logic [15:0] w_rd   [2];
    logic        w_busy [2];
    logic        w_wr_ok;
    logic        w_full;
    logic        w_inc_ok;

    assign w_addr[0] = i_p0_addr;
    assign w_addr[1] = i_p1_addr;
    assign w_re[0]   = i_re0;
    assign w_re[1]   = i_re1;
    assign w_wr_ok   = i_we && (i_dst_addr != 4'd0);

    // A register whose last pending write lands this cycle reads via bypass,
    // so it is busy only if more than that one write is outstanding.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            w_rd[n]   = 16'h0000;
            w_busy[n] = 1'b0;
            if (w_re[n] && (w_addr[n] != 4'd0)) begin
                if (w_wr_ok && (i_dst_addr == w_addr[n])) begin
                    w_rd[n]   = i_dst;
                    w_busy[n] = (r_cnt[w_addr[n]] > 2'd1);
                end else begin
                    w_rd[n]   = r_regs[w_addr[n]];
                    w_busy[n] = (r_cnt[w_addr[n]] != 2'd0);
                end
            end
        end
    end

    assign o_p0 = w_rd[0];
    assign o_p1 = w_rd[1];

    assign w_full = i_issue_valid && (i_issue_addr != 4'd0) &&
                    (r_cnt[i_issue_addr] == 2'd3) &&
                    !(i_we && (i_dst_addr == i_issue_addr));

    assign o_stall  = w_busy[0] || w_busy[1] || w_full;
    assign w_inc_ok = i_issue_valid && (i_issue_addr != 4'd0) && !o_stall;

    always_comb begin
        for (int r = 0; r < 16; r++) begin
            logic v_inc;
            logic v_dec;
            v_inc = w_inc_ok && (i_issue_addr == 4'(r));
            v_dec = w_wr_ok && (i_dst_addr == 4'(r)) && (r_cnt[r] != 2'd0);
            w_cnt_nxt[r] = r_cnt[r];
            if (r == 0) begin
                w_cnt_nxt[r] = 2'd0;
            end else if (v_inc && !v_dec) begin
                if (r_cnt[r] != 2'd3) w_cnt_nxt[r] = r_cnt[r] + 2'd1;
            end else if (v_dec && !v_inc) begin
                w_cnt_nxt[r] = r_cnt[r] - 2'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int r = 0; r < 16; r++) begin
                if (r == 15)      r_regs[r] <= SP_INIT;
                else if (r == 14) r_regs[r] <= DS_INIT;
                else              r_regs[r] <= 16'h0000;
                r_cnt[r] <= 2'd0;
            end
        end else begin
            if (w_wr_ok) r_regs[i_dst_addr] <= i_dst;
            for (int r = 0; r < 16; r++) r_cnt[r] <= w_cnt_nxt[r];
        end
    end

endmodule

// File: doc/reg_file.md
# reg_file

Architectural register file for the 16-bit pipeline: sixteen 16-bit registers with two combinational read ports and one write port. It is the responder for the decode stage's read requests (`p0_addr`/`re0`, `p1_addr`/`re1` to `p0`/`p1`) and the sink for writeback. It keeps a per-register pending-write scoreboard so decode can stall on read-after-write hazards. Write data is bypassed to same-cycle reads.

## Interface
- `SP_INIT`, default 16'hFFFF: reset value of R15 (SP).
- `DS_INIT`, default 16'h0000: reset value of R14 (DS).
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `p0_addr`  in  4  read port 0 address.
- `p1_addr`  in  4  read port 1 address.
- `re0`  in  1  read enable, port 0.
- `re1`  in  1  read enable, port 1.
- `p0`  out  16  read data, port 0 (combinational).
- `p1`  out  16  read data, port 1 (combinational).
- `we`  in  1  writeback enable.
- `dst_addr`  in  4  writeback register address.
- `dst`  in  16  writeback data.
- `issue_valid`  in  1  an instruction with a register destination leaves decode this cycle.
- `issue_addr`  in  4  destination register of the issuing instruction.
- `stall`  out  1  decode must hold: operand not ready, or scoreboard full.

## Operation
- Storage: `regs[0..15]`, 16 bits each. R0 always reads 16'h0000. Writes to R0 are discarded and never scoreboarded.
- Read port n:
  - If `re_n` = 0, `p_n` = 16'h0000.
  - Else if `we` and `dst_addr` = `p_n_addr` ≠ 0, `p_n` = `dst` (bypass).
  - Else `p_n` = `regs[p_n_addr]`.
- Write: on a clock edge with `we` and `dst_addr` ≠ 0, `regs[dst_addr]` ← `dst`.
- Scoreboard: 2-bit saturating pending counter `cnt[r]` per register; `cnt[0]` is always 0.
  - `issue_valid` with `issue_addr` ≠ 0 increments `cnt[issue_addr]`.
  - `we` with `dst_addr` ≠ 0 and `cnt[dst_addr]` > 0 decrements `cnt[dst_addr]`.
  - Increment and decrement of the same register in one cycle leave it unchanged.
  - `we` with `cnt` = 0 writes data only; the counter does not go below 0.
- Busy for a read port: `busy_n` = `re_n` and `p_n_addr` ≠ 0 and `eff_cnt[p_n_addr]` > 0.
  - `eff_cnt[r]` = `cnt[r]` − 1 when `we` and `dst_addr` = r, else `cnt[r]`. A register whose last pending write lands this cycle is read via bypass and is not busy.
- Full: `full` = `issue_valid` and `issue_addr` ≠ 0 and `cnt[issue_addr]` = 3 and not (`we` and `dst_addr` = `issue_addr`).
- `stall` = `busy_0` or `busy_1` or `full`.
- Stall gating: while `stall` = 1, the scoreboard ignores `issue_valid` (no increment). Writeback decrements still apply.
- Reset: all `regs` = 0 except R14 = `DS_INIT` and R15 = `SP_INIT`; all `cnt` = 0. Reset overrides same-cycle `we` and `issue_valid`.

## Timing
- Reads: zero latency, purely combinational from address, enable and write-port inputs.
- A write becomes visible through storage on the cycle after the edge that captures it. In the capture cycle it is visible through the bypass.
- `stall` is combinational and is valid in the same cycle as its inputs.
- Scoreboard changes take effect on the next edge.
- Outputs during and after reset:
  - `p0`/`p1` follow the reset contents (e.g. reading R15 gives `SP_INIT`).
  - `stall` = 0 unless `full` is asserted; it cannot be, since all `cnt` = 0.
- Reset mid-operation discards all pending scoreboard state. Writebacks arriving after reset for pre-reset issues update data, and their decrements are clamped at 0.

## Test plan
- Reset with default parameters; read R15 on p0 and R14 on p1 (`re0` = `re1` = 1) → p0 = 16'hFFFF, p1 = 16'h0000. Read R3 → 16'h0000. `stall` = 0.
- `we` = 1, `dst_addr` = 5, `dst` = 16'h1234, with `p0_addr` = 5 in the same cycle → p0 = 16'h1234 (bypass). Next cycle with `we` = 0 → p0 = 16'h1234 (from storage).
- Write R0 with 16'hBEEF, and issue to R0 → p0 reading R0 = 16'h0000, `stall` stays 0.
- Issue to R7; next cycle, `p1_addr` = 7 with `re1` = 1 → `stall` = 1. Same check with `re1` = 0 → `stall` = 0. Then `we` to R7 with 16'h00AA → `stall` = 0 that cycle, and p1 = 16'h00AA.
- Issue to R9 three times, then a fourth issue → `stall` = 1 and `cnt` stays at 3. Repeat the fourth issue with `we` to R9 in the same cycle → `stall` = 0 and `cnt` stays at 3.
- Issue to R4 twice. Assert `rst` for one cycle, then read R4 → `stall` = 0. A later `we` to R4 → data written, `cnt[4]` stays 0.
